led_divider: RTL and testbench

//   Clock divider producing the slow scan clock for the elevator controller's LED /

---
 rtl/led_divider_pkg.sv | 14 +
 rtl/led_divider.sv | 37 +++
 tb/tb_led_divider.sv | 138 +++++++++++++
 3 files changed

// File: rtl/led_divider_pkg.sv
// Shared clock-rate constants for the elevator controller's display scan clock.
// LED_HALF_COUNT is the number of system-clock cycles per scan-clock half-period.
package led_divider_pkg;

    localparam int SYS_CLK_HZ     = 50_000_000;
    localparam int LED_SCAN_HZ    = 1_000;
    localparam int LED_HALF_COUNT = SYS_CLK_HZ / (2 * LED_SCAN_HZ);

    // Counter width for a given half-period; never narrower than one bit.
    function automatic int cnt_width(input int half_count);
        return (half_count > 1) ? $clog2(half_count) : 1;
    endfunction

endpackage

// File: rtl/led_divider.sv
// Divides clk by 2*HALF_COUNT to produce the display multiplexing scan clock.
// led_clk comes straight from a flip-flop: glitch-free, 50 % duty cycle.
module led_divider
    import led_divider_pkg::*;
#(
    parameter int HALF_COUNT = LED_HALF_COUNT
) (
    input  logic clk,
    input  logic reset,
    output logic led_clk
);

    localparam int              CNT_W = cnt_width(HALF_COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_COUNT - 1);

    generate
        if (HALF_COUNT < 1) begin : g_bad_half_count
            $error("led_divider: HALF_COUNT must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] counter;

    // The counter wraps at LAST, never at 2^CNT_W; with HALF_COUNT=1 it stays at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            led_clk <= 1'b0;
        end else if (counter == LAST) begin
            counter <= '0;
            led_clk <= ~led_clk;
        end else begin
            counter <= counter + 1'b1;
        end
    end

endmodule

// File: tb/tb_led_divider.sv
// Bench for led_divider: five instances (HALF_COUNT 4, 1, 3, 5 and default)
// share one clock; expected led_clk values are queued by cycle and checked by a monitor.
module tb_led_divider;

    typedef struct {
        int    due;
        int    dut;
        logic  exp;
        string name;
    } item_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
    logic led0, led1, led2, led3, led4;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    item_t exp_q[$];

    always #1 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_divider #(.HALF_COUNT(4)) u_h4 (.clk(clk), .reset(rst0), .led_clk(led0));
    led_divider #(.HALF_COUNT(1)) u_h1 (.clk(clk), .reset(rst1), .led_clk(led1));
    led_divider #(.HALF_COUNT(3)) u_h3 (.clk(clk), .reset(rst2), .led_clk(led2));
    led_divider #(.HALF_COUNT(5)) u_h5 (.clk(clk), .reset(rst3), .led_clk(led3));
    led_divider                   u_hd (.clk(clk), .reset(rst4), .led_clk(led4));

    function automatic logic led_of(input int d);
        case (d)
            0:       return led0;
            1:       return led1;
            2:       return led2;
            3:       return led3;
            default: return led4;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int due, input logic v, input string nm);
        item_t it;
        it.due  = due;
        it.dut  = d;
        it.exp  = v;
        it.name = nm;
        exp_q.push_back(it);
    endtask

    // Push one expected value per clock edge from a '0'/'1' string, edge by edge.
    task automatic play(input int d, input string pat, input string nm);
        for (int k = 0; k < pat.len(); k++) begin
            push(d, cyc + 1, pat.getc(k) == "1", nm);
            @(negedge clk);
        end
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) begin
                if (exp_q[i].due < cyc)
                    check({exp_q[i].name, "_stale"}, exp_q[i].due, cyc);
                else
                    check(exp_q[i].name, int'(led_of(exp_q[i].dut)), int'(exp_q[i].exp));
                exp_q.delete(i);
            end
        end
    end

    initial begin
        @(negedge clk);
        fork
            begin : small_tests
                int highs, rises, falls;
                logic prev;
                // Reset held for 20 cycles: led_clk must stay low.
                for (int i = 0; i < 20; i++) begin
                    push(0, cyc + 1, 1'b0, "hold_reset");
                    push(1, cyc + 1, 1'b0, "h1_in_reset");
                    @(negedge clk);
                end
                // HALF_COUNT=4: rise on edge 4, fall on edge 8, period 8.
                rst0 = 1'b0;
                play(0, "000111100001111000011110", "h4_wave");
                // HALF_COUNT=1: toggles every edge.
                rst1 = 1'b0;
                play(1, "10101010", "h1_wave");
                // HALF_COUNT=3: two periods plus a rise, then reset while high.
                rst2 = 1'b0;
                play(2, "001110001110001", "h3_wave");
                rst2 = 1'b1;
                push(2, cyc + 1, 1'b0, "h3_mid_reset");
                @(negedge clk);
                rst2 = 1'b0;
                play(2, "0011100", "h3_after_reset");
                // HALF_COUNT=5 over 100 edges: rises at 5,15,..,95; falls at 10,..,100.
                rst3 = 1'b0;
                highs = 0; rises = 0; falls = 0; prev = 1'b0;
                for (int k = 1; k <= 100; k++) begin
                    push(3, cyc + 1, ((k / 5) % 2) == 1, "h5_wave");
                    @(negedge clk);
                    if (led3) highs++;
                    if (led3 && !prev) rises++;
                    if (!led3 && prev) falls++;
                    prev = led3;
                end
                check("h5_rises", rises, 10);
                check("h5_falls", falls, 10);
                check("h5_high_cycles", highs, 50);
            end
            begin : default_test
                int c0;
                rst4 = 1'b0;
                c0 = cyc;
                push(4, c0 + 24999, 1'b0, "dflt_before_rise");
                push(4, c0 + 25000, 1'b1, "dflt_rise");
                push(4, c0 + 49999, 1'b1, "dflt_before_fall");
                push(4, c0 + 50000, 1'b0, "dflt_fall");
                repeat (50002) @(negedge clk);
            end
        join
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            check({exp_q[0].name, "_unchecked"}, 0, 1);
            void'(exp_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
